// File: rtl/seq_run_ctrl.sv
`timescale 1ns/1ps
// Sequenced run controller for the 3-bit generator family: steps Q through the
// selected sequence a bounded number of times, with pause, abort and done pulse.
module seq_run_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] steps,
    output logic [2:0]        Q,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_q, w_q_nxt, w_adv;
    logic              r_wrap, w_wrap_nxt;
    logic [1:0]        r_mode, w_mode_nxt;
    logic [STEP_W-1:0] r_left, w_left_nxt;
    logic              w_last;

    // Successor of q in the sequence for mode m; values off the sequence fall back to 000.
    function automatic logic [2:0] f_next(input logic [1:0] m, input logic [2:0] q);
        logic [2:0] r;
        r = 3'd0;
        case (m)
            2'd0: begin
                case (q)
                    3'd0: r = 3'd1;
                    3'd1: r = 3'd3;
                    3'd3: r = 3'd5;
                    3'd5: r = 3'd7;
                    default: r = 3'd0;
                endcase
            end
            2'd1: r = q + 3'd1;
            2'd2: begin
                case (q)
                    3'd0: r = 3'd1;
                    3'd1: r = 3'd3;
                    3'd3: r = 3'd2;
                    3'd2: r = 3'd6;
                    3'd6: r = 3'd7;
                    3'd7: r = 3'd5;
                    3'd5: r = 3'd4;
                    default: r = 3'd0;
                endcase
            end
            default: begin
                case (q)
                    3'd0: r = 3'd1;
                    3'd1: r = 3'd3;
                    3'd3: r = 3'd7;
                    3'd7: r = 3'd6;
                    3'd6: r = 3'd4;
                    default: r = 3'd0;
                endcase
            end
        endcase
        return r;
    endfunction

    assign w_adv  = f_next(r_mode, r_q);
    assign w_last = (r_left == STEP_W'(1)) || (r_left == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_wrap_nxt  = 1'b0;
        w_mode_nxt  = r_mode;
        w_left_nxt  = r_left;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode_nxt  = mode;
                    w_left_nxt  = steps;
                    w_q_nxt     = 3'd0;
                    w_state_nxt = (steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (pause) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_q_nxt    = w_adv;
                    w_wrap_nxt = (w_adv == 3'd0) && (r_q != 3'd0);
                    if (r_left != '0) begin
                        w_left_nxt = r_left - STEP_W'(1);
                    end
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            // Resume edge only returns to RUN; the next advance happens one edge later.
            S_PAUSE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_q     <= 3'd0;
            r_wrap  <= 1'b0;
            r_mode  <= 2'd0;
            r_left  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_wrap  <= w_wrap_nxt;
            r_mode  <= w_mode_nxt;
            r_left  <= w_left_nxt;
        end
    end

    assign Q     = r_q;
    assign state = r_state;
    assign busy  = (r_state == S_RUN) || (r_state == S_PAUSE);
    assign done  = (r_state == S_DONE);
    assign wrap  = r_wrap;

endmodule

// File: tb/tb_seq_run_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for seq_run_ctrl: run-level reference model pushes expected
// per-cycle outputs; an independent monitor pops and compares after each edge.
module tb_seq_run_ctrl;

    localparam int STEP_W = 8;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAU = 2'd2, DN = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b0, start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [STEP_W-1:0] steps = '0;
    logic [2:0]        Q;
    logic              busy, done, wrap;
    logic [1:0]        state;

    seq_run_ctrl #(.STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .steps(steps), .Q(Q), .busy(busy), .done(done),
        .wrap(wrap), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] q;
        logic [1:0] st;
        logic       busy;
        logic       done;
        logic       wrap;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_cyc = 0;
    logic [2:0] mq = 3'd0;

    task automatic chk(string nm, int got, int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, n_cyc, got, expv);
        end
    endtask

    // Monitor: compares whatever the DUT shows after each edge against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("Q",     int'(Q),     int'(mon_e.q));
                chk("state", int'(state), int'(mon_e.st));
                chk("busy",  int'(busy),  int'(mon_e.busy));
                chk("done",  int'(done),  int'(mon_e.done));
                chk("wrap",  int'(wrap),  int'(mon_e.wrap));
            end
        end
    end

    function automatic exp_t E(logic [2:0] q, logic [1:0] st, bit b, bit d, bit w);
        exp_t r;
        r.q = q; r.st = st; r.busy = b; r.done = d; r.wrap = w;
        return r;
    endfunction

    // Reference sequences as plain lists; successor is the following list entry.
    function automatic logic [2:0] ref_next(int m, logic [2:0] q);
        int s[$];
        case (m)
            0:       s = '{0, 1, 3, 5, 7};
            1:       s = '{0, 1, 2, 3, 4, 5, 6, 7};
            2:       s = '{0, 1, 3, 2, 6, 7, 5, 4};
            default: s = '{0, 1, 3, 7, 6, 4};
        endcase
        foreach (s[i]) if (s[i] == int'(q)) return 3'(s[(i + 1) % s.size()]);
        return 3'd0;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic bit rstart();
        return ($urandom_range(0, 3) == 0);
    endfunction

    task automatic cyc(bit rs, bit st, bit sp, bit pa, logic [1:0] m, logic [STEP_W-1:0] n, exp_t e);
        @(posedge clk);
        #2;
        reset = rs; start = st; stop = sp; pause = pa; mode = m; steps = n;
        sbq.push_back(e);
    endtask

    task automatic do_reset();
        cyc(1'b1, rb(), rb(), rb(), 2'($urandom), STEP_W'($urandom), E(3'd0, IDLE, 0, 0, 0));
        mq = 3'd0;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, rb(), rb(), 2'($urandom), STEP_W'($urandom), E(mq, IDLE, 0, 0, 0));
    endtask

    // One run from the start command; optional pause window, abort or reset point,
    // each keyed on the number of advances already made.
    task automatic run(int m, int n, int pause_at = -1, int pause_len = 0, int stop_at = -1,
                       bit stop_pause = 0, int reset_at = -1, bit reset_in_pause = 0);
        int k;
        int pa_at;
        logic [2:0] nq;
        k = 0;
        pa_at = pause_at;
        cyc(1'b0, 1'b1, rb(), rb(), 2'(m), STEP_W'(n),
            E(3'd0, (n == 0) ? DN : RUN, n != 0, n == 0, 0));
        mq = 3'd0;
        while (k < n) begin
            if (k == pa_at) begin
                for (int i = 0; i < pause_len; i++)
                    cyc(1'b0, rstart(), 1'b0, 1'b1, 2'($urandom), STEP_W'($urandom), E(mq, PAU, 1, 0, 0));
                pa_at = -1;
                if (reset_in_pause) begin
                    do_reset();
                    return;
                end
                if (k == stop_at) begin
                    cyc(1'b0, rstart(), 1'b1, 1'b1, 2'($urandom), STEP_W'($urandom), E(mq, IDLE, 0, 0, 0));
                    return;
                end
                cyc(1'b0, rstart(), 1'b0, 1'b0, 2'($urandom), STEP_W'($urandom), E(mq, RUN, 1, 0, 0));
            end
            if (k == stop_at) begin
                cyc(1'b0, rstart(), 1'b1, stop_pause, 2'($urandom), STEP_W'($urandom), E(mq, IDLE, 0, 0, 0));
                return;
            end
            if (k == reset_at) begin
                do_reset();
                return;
            end
            nq = ref_next(m, mq);
            k++;
            cyc(1'b0, rstart(), 1'b0, 1'b0, 2'($urandom), STEP_W'($urandom),
                E(nq, (k == n) ? DN : RUN, k < n, k == n, (nq == 3'd0) && (mq != 3'd0)));
            mq = nq;
        end
        // Start during the DONE cycle must be dropped.
        cyc(1'b0, 1'b1, rb(), rb(), 2'($urandom), STEP_W'($urandom), E(mq, IDLE, 0, 0, 0));
    endtask

    initial begin
        int m, n, c, a;
        do_reset();
        do_reset();
        idle_cyc();
        run(0, 5);
        idle_cyc();
        run(2, 3);
        idle_cyc();
        idle_cyc();
        run(1, 10);
        run(1, 4, 2, 3);
        run(3, 6, -1, 0, 2, 1);
        idle_cyc();
        run(3, 6, -1, 0, 2, 0);
        run(0, 0);
        run(1, 5);
        run(0, 6, 1, 2, 1);
        run(1, 8, 3, 2, -1, 0, -1, 1);
        run(2, 7, -1, 0, -1, 0, 4);
        run(2, 9, 0, 1);
        run(1, 255);
        for (int it = 0; it < 60; it++) begin
            m = int'($urandom_range(0, 3));
            n = int'($urandom_range(0, 14));
            c = (n == 0) ? 0 : int'($urandom_range(0, 4));
            a = (n == 0) ? 0 : int'($urandom_range(0, n - 1));
            case (c)
                0: run(m, n);
                1: run(m, n, a, int'($urandom_range(1, 4)));
                2: run(m, n, -1, 0, a, rb());
                3: run(m, n, -1, 0, -1, 0, a);
                default: begin
                    if (rb()) run(m, n, a, int'($urandom_range(1, 3)), a);
                    else      run(m, n, a, int'($urandom_range(1, 3)), -1, 0, -1, 1);
                end
            endcase
            if (rb()) idle_cyc();
        end
        repeat (2) @(posedge clk);
        #3;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_run_ctrl.md
# seq_run_ctrl

Run controller for the 3-bit sequence generator family. Accepts a start command with a sequence mode and a step count, and advances a 3-bit state output through the selected sequence one step per clock. Supports pause and abort, and signals completion with a one-cycle done pulse. Sits between the lab top-level control inputs and the LED/display Q outputs, replacing free-running generators with a sequenced, bounded run.

## Interface
- `STEP_W`, default 8: width of the step counter and the `steps` input.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous, active-high. Takes effect on the rising edge of `clk`.
- `start`: input, 1 bit. Run request. Sampled only in IDLE.
- `stop`: input, 1 bit. Abort request. Level-sensitive.
- `pause`: input, 1 bit. Hold request. Level-sensitive.
- `mode`: input, 2 bits. Selects the sequence. Latched at start.
- `steps`: input, STEP_W bits. Number of advances to perform. Latched at start.
- `Q`: output, 3 bits. Current sequence value. Registered.
- `busy`: output, 1 bit. High in RUN or PAUSE.
- `done`: output, 1 bit. One-cycle pulse on normal completion.
- `wrap`: output, 1 bit. One-cycle pulse when an advance returns Q to 000.
- `state`: output, 2 bits. FSM state encoding: IDLE=00, RUN=01, PAUSE=10, DONE=11.

## Operation

**Sequences.** Next value of Q for each latched mode:
- Mode 0 (odd-skip): 000→001→011→101→111→000.
- Mode 1 (binary): 000→001→…→111→000.
- Mode 2 (Gray): 000→001→011→010→110→111→101→100→000.
- Mode 3 (Johnson): 000→001→011→111→110→100→000.
- Any Q value not in the latched mode's sequence maps to 000.

**FSM states.**
- **IDLE:**
  - `start`=1 latches `mode` and `steps` and loads Q=000.
  - If `steps`=0, go to DONE; otherwise go to RUN.
  - `stop` and `pause` are ignored in IDLE.
- **RUN:**
  - `stop`=1 → IDLE. Q holds, no `done`.
  - Else `pause`=1 → PAUSE. Q holds, no advance.
  - Else Q ← next(Q) and steps_left ← steps_left−1.
  - If steps_left was 1 → DONE.
- **PAUSE:**
  - `stop`=1 → IDLE.
  - Else `pause`=0 → RUN. No advance occurs on the resume edge.
  - Else remain in PAUSE.
- **DONE:** `done`=1 for exactly one cycle, then → IDLE unconditionally. Q holds.

**Priority and edge rules.**
- Priority is `reset` > `stop` > `pause` > advance.
- `start` asserted outside IDLE is ignored and is not queued.
- `mode`/`steps` changes after start have no effect until the next start.
- Q holds its final value in DONE and in IDLE, until the next start or reset.
- steps_left is STEP_W bits wide and never underflows; there is no decrement in IDLE, PAUSE or DONE.
- `wrap` is registered alongside Q. It is 1 in the cycle after an advance that produced 000 from a nonzero value. The start load to 000 does not raise `wrap`.

## Timing
- **Reset values:** Q=000, state=IDLE, `busy`=0, `done`=0, `wrap`=0, steps_left=0.
- **Reset mid-run:** reset in any state returns to IDLE on that edge. No `done` is produced.
- **Start, N>0:** start sampled at edge E0 → RUN, Q=000, `busy`=1 after E0.
  - Advances occur at edges E1…EN, with no pause or stop.
  - After EN: state=DONE, `done`=1, `busy`=0.
  - After EN+1: IDLE.
- **Start, N=0:** after E0: DONE, Q=000. After E1: IDLE.
- **Pause:** each cycle spent in PAUSE, and the resume edge, add exactly one cycle to the run. The total number of advances is still N.
- **Pulse widths:** `done` and `wrap` are single-cycle pulses. Both can be 1 in the same cycle, when the final advance lands on 000.
- **Restart:** a start asserted during the DONE cycle is ignored. The earliest restart is sampled in the following IDLE cycle.

## Test plan
1. **Mode 0, full cycle.** Reset, then start with mode 0, steps=5. Expect Q=000,001,011,101,111,000 on consecutive cycles. On the final cycle, `wrap`=1 and `done`=1 together. Then IDLE with Q=000 and `busy`=0.
2. **Mode 2, partial run.** Start with mode 2, steps=3. Expect Q=000,001,011,010, then `done` and Q holding at 010 in IDLE. Then start with mode 1, steps=10. Expect Q to count 0..7, then 0,1,2, with `wrap` high once.
3. **Pause.** Mode 1, steps=4. Assert `pause` for 3 cycles after Q reaches 010. Expect Q to hold at 010 and state=PAUSE. After release, expect Q=011,100 and `done`. Total run is 4 advances.
4. **Abort.** Mode 3, steps=6. Assert `stop` while Q=011. Expect IDLE on the next edge, Q holding at 011, and no `done` pulse. Assert `stop`+`pause` together in RUN: stop wins.
5. **Zero steps and ignored start.** Start with steps=0. Expect `done` one cycle after start, Q=000, and no `wrap`. A start pulse during RUN is ignored: the run length is unchanged and no second run follows.
6. **Reset mid-run.** Assert `reset` during PAUSE, and separately during RUN. Expect Q=000, IDLE, and all outputs 0 on the next edge, with no `done`.
